// File: rtl/debug_dump_sequencer.sv
// Debug dump sequencer: scans the debug latch controllers one at a time,
// collects their frames into a small FIFO and streams them to the host.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for i_start
// SELECT    | drive controller ID, clear wait counter
// WAIT_WR   | wait for i_writing, give up after TIMEOUT+1 cycles
// CAPTURE   | push a frame every cycle i_writing is high
// DRAIN     | wait for the FIFO to empty towards the host
// GAP       | one cycle with no select, then next ID or finish
// DONE      | one-cycle completion pulse
module debug_dump_sequencer #(
    parameter int NB_FRAME   = 32,
    parameter int N_CTRL     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    output logic [5:0]          o_request_select,
    input  logic                i_writing,
    input  logic [NB_FRAME-1:0] i_frame,
    output logic [NB_FRAME-1:0] o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic [1:0]          o_error
);

    localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              WW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [5:0]      SEL_NONE = 6'h3F;
    localparam logic [5:0]      LAST_IDX = 6'(N_CTRL - 1);
    localparam logic [WW-1:0]   WAIT_MAX = WW'(TIMEOUT);
    localparam logic [PW:0]     FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, SELECT, WAIT_WR, CAPTURE, DRAIN, GAP, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      idx_q, idx_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [1:0]      err_q, err_d;

    logic [NB_FRAME-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [PW:0]     cnt_q;

    logic            push_req;
    logic            pop;
    logic            full;
    logic            push_ok;

    assign o_tx_valid = (cnt_q != '0);
    assign o_tx_data  = mem_q[rptr_q];
    assign o_error    = err_q;
    assign pop        = o_tx_valid & i_tx_ready;
    assign full       = (cnt_q == FULL_CNT);
    // A full FIFO still takes a frame when the head leaves in the same cycle.
    assign push_ok    = push_req & (~full | pop);

    // Sequencer registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next-state, select/status outputs and sticky error flags.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        wait_d           = wait_q;
        err_d            = err_q;
        push_req         = 1'b0;
        o_request_select = SEL_NONE;
        o_busy           = 1'b1;
        o_done           = 1'b0;
        case (state_q)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    idx_d   = '0;
                    err_d   = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                o_request_select = idx_q;
                wait_d           = '0;
                state_d          = WAIT_WR;
            end
            WAIT_WR: begin
                o_request_select = idx_q;
                if (i_writing) begin
                    push_req = 1'b1;
                    state_d  = CAPTURE;
                end else if (wait_q == WAIT_MAX) begin
                    err_d[0] = 1'b1;
                    state_d  = GAP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            CAPTURE: begin
                o_request_select = idx_q;
                if (i_writing) begin
                    push_req = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!o_tx_valid) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = SELECT;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (push_req && full && !pop) begin
            err_d[1] = 1'b1;
        end
    end

    // Frame FIFO: wrap-around pointers plus an occupancy count.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= i_frame;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + (PW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
